// File: rtl/vend_coin_sched.sv
// Coin scheduler for the vending core: round-robin arbitration of two coin slots,
// single-cycle coin pulses with enforced idle gaps, dispense hold-off and saturating counters.
module vend_coin_sched #(
    parameter int GAP      = 1,
    parameter int DISP_CYC = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [1:0]       a_coin,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [1:0]       b_coin,
    output logic             b_ready,
    output logic [1:0]       core_in,
    input  logic [1:0]       core_y,
    output logic             busy,
    output logic             reject,
    output logic [CNT_W-1:0] coin_cnt,
    output logic [CNT_W-1:0] vend_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CHECK,
        ST_GAP,
        ST_DISPENSE
    } state_e;

    localparam int TMR_MAX = (DISP_CYC > GAP) ? DISP_CYC : GAP;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'((GAP > 1) ? GAP - 2 : 0);
    localparam logic [TMR_W-1:0] DISP_LOAD = TMR_W'(DISP_CYC - 1);

    state_e           state_q, state_d;
    logic             ptr_q, ptr_d;        // 0 = slot A has priority, 1 = slot B
    logic [1:0]       core_in_q, core_in_d;
    logic             busy_q, busy_d;
    logic             reject_q, reject_d;
    logic [CNT_W-1:0] coin_cnt_q, coin_cnt_d;
    logic [CNT_W-1:0] vend_cnt_q, vend_cnt_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;

    logic       idle_ok;
    logic       grant_a;
    logic       grant_b;
    logic       accept;
    logic [1:0] acc_coin;

    // NOTE: ready is combinational, so it is gated by rst directly; otherwise a
    // slot could see ready during reset while the flops are still being cleared.
    assign idle_ok  = (state_q == ST_IDLE) && !rst;
    assign grant_a  = idle_ok && a_valid && (!b_valid || !ptr_q);
    assign grant_b  = idle_ok && b_valid && (!a_valid || ptr_q);
    assign accept   = grant_a || grant_b;
    assign acc_coin = grant_b ? b_coin : a_coin;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        core_in_d  = 2'b00;
        reject_d   = 1'b0;
        coin_cnt_d = coin_cnt_q;
        vend_cnt_d = vend_cnt_q;
        tmr_d      = tmr_q;

        if (accept) begin
            ptr_d = grant_a;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    // Only 10 and 11 are real coins; 01 and 00 are swallowed.
                    if (acc_coin[1]) begin
                        core_in_d = acc_coin;
                        state_d   = ST_ISSUE;
                        if (coin_cnt_q != {CNT_W{1'b1}}) begin
                            coin_cnt_d = coin_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (core_y != 2'b00) begin
                    if (vend_cnt_q != {CNT_W{1'b1}}) begin
                        vend_cnt_d = vend_cnt_q + CNT_W'(1);
                    end
                    state_d = ST_DISPENSE;
                    tmr_d   = DISP_LOAD;
                end else if (GAP > 1) begin
                    state_d = ST_GAP;
                    tmr_d   = GAP_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP, ST_DISPENSE: begin
                if (tmr_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 1'b0;
            core_in_q  <= 2'b00;
            busy_q     <= 1'b0;
            reject_q   <= 1'b0;
            coin_cnt_q <= '0;
            vend_cnt_q <= '0;
            tmr_q      <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            core_in_q  <= core_in_d;
            busy_q     <= busy_d;
            reject_q   <= reject_d;
            coin_cnt_q <= coin_cnt_d;
            vend_cnt_q <= vend_cnt_d;
            tmr_q      <= tmr_d;
        end
    end

    assign a_ready  = grant_a;
    assign b_ready  = grant_b;
    assign core_in  = core_in_q;
    assign busy     = busy_q;
    assign reject   = reject_q;
    assign coin_cnt = coin_cnt_q;
    assign vend_cnt = vend_cnt_q;

endmodule
